// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forward selects,
// default load writeback encoding and the MDU sequencer states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_W      = 2'b01;
    localparam logic [1:0] FWD_M      = 2'b10;
    localparam logic [1:0] WB_MEM_DEF = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit bundle: register addresses and stage controls in,
// stall/flush/forward selects and performance counters out.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic              rs1_usedD, rs2_usedD;
    logic              regwriteE, regwriteM, regwriteW;
    logic [1:0]        wbselE;
    logic              pcselE, mdu_startE, mdu_doneE;
    logic              stallF, stallD, stallE;
    logic              flushD, flushE, flushM;
    logic [1:0]        forwardAE, forwardBE;
    logic              mdu_busy;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;

    modport master (
        output rs1D, rs2D, rs1_usedD, rs2_usedD, rs1E, rs2E, rdE, rdM, rdW,
               regwriteE, regwriteM, regwriteW, wbselE, pcselE, mdu_startE, mdu_doneE,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, mdu_busy, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1_usedD, rs2_usedD, rs1E, rs2E, rdE, rdM, rdW,
               regwriteE, regwriteM, regwriteW, wbselE, pcselE, mdu_startE, mdu_doneE,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, mdu_busy, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_unit_mc_mdu_fsm.sv
// MDU sequencer: holds the E stage while a mul/div op is in flight, finishing
// after a fixed cycle count or on the unit's done strobe.
module hazard_mdu_fsm
    import hazard_pkg::*;
#(
    parameter int MDU_VAR = 0,
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_start_i,
    input  logic mdu_done_i,
    output logic mdustall_o,
    output logic mdu_busy_o,
    output logic mdu_idle_o
);
    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    mdu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          complete_s;
    logic          mdustall_s;

    assign complete_s = (MDU_VAR == 0) ? (cnt_q == CW'(MDU_LAT - 1)) : mdu_done_i;

    // State and busy-cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; DONE ignores mdu_startE because that op is still leaving E
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdustall_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_start_i) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    mdustall_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                mdustall_s = 1'b1;
                if (complete_s) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdustall_o = mdustall_s;
    assign mdu_busy_o = (state_q != IDLE);
    assign mdu_idle_o = (state_q == IDLE);
endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use / RAW interlock,
// branch flush, MDU hold of the E stage and saturating stall/flush counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int         REG_AW  = 5,
    parameter int         FWD_EN  = 1,
    parameter int         MDU_VAR = 0,
    parameter int         MDU_LAT = 4,
    parameter logic [1:0] WB_MEM  = WB_MEM_DEF,
    parameter int         CNT_W   = 32
) (
    input logic             clk,
    input logic             rst,
    hazard_unit_mc_if.slave hz
);
    logic mdustall_s, mdu_busy_s, mdu_idle_s;
    logic use_e_s, use_m_s, lwstall_s, rawstall_s, pcsel_eff_s, dstall_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic stall_f_s, stall_d_s, stall_e_s, flush_d_s, flush_e_s, flush_m_s;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    hazard_mdu_fsm #(.MDU_VAR(MDU_VAR), .MDU_LAT(MDU_LAT)) u_mdu (
        .clk         (clk),
        .rst         (rst),
        .mdu_start_i (hz.mdu_startE),
        .mdu_done_i  (hz.mdu_doneE),
        .mdustall_o  (mdustall_s),
        .mdu_busy_o  (mdu_busy_s),
        .mdu_idle_o  (mdu_idle_s)
    );

    function automatic logic uses_reg(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] r1,
                                      input logic [REG_AW-1:0] r2, input logic u1, input logic u2);
        return (x != '0) && ((u1 && (r1 == x)) || (u2 && (r2 == x)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd_m,
                                           input logic [REG_AW-1:0] rd_w, input logic we_m, input logic we_w);
        logic [1:0] sel;
        if (we_m && (rd_m != '0) && (rs == rd_m)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != '0) && (rs == rd_w)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard detection; without forwarding, any pending E/M write is a RAW stall
    always_comb begin
        use_e_s   = uses_reg(hz.rdE, hz.rs1D, hz.rs2D, hz.rs1_usedD, hz.rs2_usedD);
        use_m_s   = uses_reg(hz.rdM, hz.rs1D, hz.rs2D, hz.rs1_usedD, hz.rs2_usedD);
        lwstall_s = hz.regwriteE && (hz.wbselE == WB_MEM) && use_e_s;
        if (FWD_EN != 0) begin
            fwd_a_s    = fwd_sel(hz.rs1E, hz.rdM, hz.rdW, hz.regwriteM, hz.regwriteW);
            fwd_b_s    = fwd_sel(hz.rs2E, hz.rdM, hz.rdW, hz.regwriteM, hz.regwriteW);
            rawstall_s = 1'b0;
        end else begin
            fwd_a_s    = FWD_RF;
            fwd_b_s    = FWD_RF;
            rawstall_s = (hz.regwriteE && use_e_s) || (hz.regwriteM && use_m_s);
        end
    end

    assign pcsel_eff_s = hz.pcselE && mdu_idle_s && !hz.mdu_startE;
    assign dstall_s    = (lwstall_s || rawstall_s) && !pcsel_eff_s;

    // Stall/flush priority: MDU hold, then branch redirect, then data interlock
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_m_s = 1'b0;
        if (mdustall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            flush_m_s = 1'b1;
        end else if (pcsel_eff_s) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (dstall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f_s && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (pcsel_eff_s && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stallF         = stall_f_s;
    assign hz.stallD         = stall_d_s;
    assign hz.stallE         = stall_e_s;
    assign hz.flushD         = flush_d_s;
    assign hz.flushE         = flush_e_s;
    assign hz.flushM         = flush_m_s;
    assign hz.forwardAE      = fwd_a_s;
    assign hz.forwardBE      = fwd_b_s;
    assign hz.mdu_busy       = mdu_busy_s;
    assign hz.perf_stall_cnt = stall_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench: dut 0 is the default build (forwarding, fixed MDU latency 4),
// dut 1 is interlock-only with variable MDU latency and 4-bit counters.
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rs1u, rs2u, rwE, rwM, rwW, pcselE, start, done;
    logic [1:0] wbselE;

    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(32)) if0 ();
    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(4))  if1 ();

    assign if0.rs1D = rs1D;   assign if1.rs1D = rs1D;
    assign if0.rs2D = rs2D;   assign if1.rs2D = rs2D;
    assign if0.rs1E = rs1E;   assign if1.rs1E = rs1E;
    assign if0.rs2E = rs2E;   assign if1.rs2E = rs2E;
    assign if0.rdE  = rdE;    assign if1.rdE  = rdE;
    assign if0.rdM  = rdM;    assign if1.rdM  = rdM;
    assign if0.rdW  = rdW;    assign if1.rdW  = rdW;
    assign if0.rs1_usedD = rs1u;   assign if1.rs1_usedD = rs1u;
    assign if0.rs2_usedD = rs2u;   assign if1.rs2_usedD = rs2u;
    assign if0.regwriteE = rwE;    assign if1.regwriteE = rwE;
    assign if0.regwriteM = rwM;    assign if1.regwriteM = rwM;
    assign if0.regwriteW = rwW;    assign if1.regwriteW = rwW;
    assign if0.wbselE    = wbselE; assign if1.wbselE    = wbselE;
    assign if0.pcselE    = pcselE; assign if1.pcselE    = pcselE;
    assign if0.mdu_startE = start; assign if1.mdu_startE = start;
    assign if0.mdu_doneE  = done;  assign if1.mdu_doneE  = done;

    hazard_unit_mc #(.REG_AW(5), .FWD_EN(1), .MDU_VAR(0), .MDU_LAT(4), .WB_MEM(2'b00), .CNT_W(32))
        dut0 (.clk(clk), .rst(rst), .hz(if0));
    hazard_unit_mc #(.REG_AW(5), .FWD_EN(0), .MDU_VAR(1), .MDU_LAT(4), .WB_MEM(2'b00), .CNT_W(4))
        dut1 (.clk(clk), .rst(rst), .hz(if1));

    // ctl bit order: {stallF, stallD, stallE, flushD, flushE, flushM}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_MDU  = 6'b111001;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_LD   = 6'b110010;

    typedef struct {
        int          dut;
        string       name;
        logic [5:0]  ctl;
        logic [1:0]  fa, fb;
        logic        busy;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cur   = 0;
    logic [31:0] msc[2];
    logic [31:0] mfc[2];

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int d);
        logic [31:0] mx;
        mx = (d == 0) ? 32'hFFFF_FFFF : 32'd15;
        return (v == mx) ? v : v + 32'd1;
    endfunction

    task automatic zero_models();
        msc[0] = 32'd0; msc[1] = 32'd0;
        mfc[0] = 32'd0; mfc[1] = 32'd0;
    endtask

    task automatic clr();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        rs1u = 1'b0; rs2u = 1'b0; rwE = 1'b0; rwM = 1'b0; rwW = 1'b0;
        wbselE = 2'b11; pcselE = 1'b0; start = 1'b0; done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected outputs for the current cycle, then advance the counter model
    task automatic chk(input string nm, input logic [5:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic busy);
        exp_t e;
        e.dut = cur; e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.busy = busy;
        e.sc = msc[cur]; e.fc = mfc[cur];
        q.push_back(e);
        if (rst) begin
            zero_models();
        end else begin
            if (ctl[5]) msc[cur] = sat_inc(msc[cur], cur);
            if (ctl[2]) mfc[cur] = sat_inc(mfc[cur], cur);
        end
    endtask

    exp_t        m_e;
    logic [5:0]  a_ctl;
    logic [1:0]  a_fa, a_fb;
    logic        a_busy;
    logic [31:0] a_sc, a_fc;

    // Monitor: compare every queued expectation against the selected DUT mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.dut == 0) begin
                a_ctl  = {if0.stallF, if0.stallD, if0.stallE, if0.flushD, if0.flushE, if0.flushM};
                a_fa   = if0.forwardAE;  a_fb = if0.forwardBE;  a_busy = if0.mdu_busy;
                a_sc   = if0.perf_stall_cnt;  a_fc = if0.perf_flush_cnt;
            end else begin
                a_ctl  = {if1.stallF, if1.stallD, if1.stallE, if1.flushD, if1.flushE, if1.flushM};
                a_fa   = if1.forwardAE;  a_fb = if1.forwardBE;  a_busy = if1.mdu_busy;
                a_sc   = {28'd0, if1.perf_stall_cnt};  a_fc = {28'd0, if1.perf_flush_cnt};
            end
            total++;
            if (a_ctl !== m_e.ctl || a_fa !== m_e.fa || a_fb !== m_e.fb || a_busy !== m_e.busy ||
                a_sc !== m_e.sc || a_fc !== m_e.fc) begin
                bad++;
                $display("FAIL %s (dut%0d): got ctl=%b fA=%b fB=%b busy=%b sc=%0d fc=%0d, want ctl=%b fA=%b fB=%b busy=%b sc=%0d fc=%0d",
                         m_e.name, m_e.dut, a_ctl, a_fa, a_fb, a_busy, a_sc, a_fc,
                         m_e.ctl, m_e.fa, m_e.fb, m_e.busy, m_e.sc, m_e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        zero_models();
        tick(); tick();
        rst = 1'b0;
        zero_models();

        cur = 0;
        chk("reset_idle", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rdM = 5'd5; rwM = 1'b1; rdW = 5'd5; rwW = 1'b1; rs1E = 5'd5;
        chk("fwdA_M_prio", C_NONE, 2'b10, 2'b00, 1'b0); tick();
        rwM = 1'b0;
        chk("fwdA_W", C_NONE, 2'b01, 2'b00, 1'b0); tick();
        rwM = 1'b1; rdM = 5'd0; rdW = 5'd0;
        chk("fwdA_x0", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rdM = 5'd6; rs2E = 5'd6; rdW = 5'd5;
        chk("fwdB_M_A_W", C_NONE, 2'b01, 2'b10, 1'b0); tick();

        clr(); wbselE = 2'b00; rwE = 1'b1; rdE = 5'd7; rs2D = 5'd7; rs2u = 1'b1;
        chk("load_use", C_LD, 2'b00, 2'b00, 1'b0); tick();
        clr();
        chk("load_use_clear", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        wbselE = 2'b00; rwE = 1'b1; rdE = 5'd7; rs2D = 5'd7; rs2u = 1'b0;
        chk("load_unused_rs2", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rs2u = 1'b1; pcselE = 1'b1;
        chk("branch_over_load", C_BR, 2'b00, 2'b00, 1'b0); tick();
        clr();
        chk("after_branch", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rst = 1'b1;
        chk("in_reset", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rst = 1'b0;

        start = 1'b1;
        chk("mdu_issue", C_MDU, 2'b00, 2'b00, 1'b0); tick();
        for (int i = 1; i <= 4; i++) begin
            pcselE = (i == 2);
            chk("mdu_busy", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        end
        pcselE = 1'b0;
        chk("mdu_done", C_NONE, 2'b00, 2'b00, 1'b1); tick();
        start = 1'b0;
        chk("mdu_idle_cnt5", C_NONE, 2'b00, 2'b00, 1'b0); tick();

        cur = 1;
        rst = 1'b1; clr(); tick();
        rst = 1'b0; zero_models();
        chk("d1_reset", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        rwM = 1'b1; rdM = 5'd3; rs1D = 5'd3; rs1u = 1'b1; rs1E = 5'd3;
        chk("nofwd_raw_M", C_LD, 2'b00, 2'b00, 1'b0); tick();
        rwM = 1'b0; rwW = 1'b1; rdW = 5'd3;
        chk("nofwd_W_no_stall", C_NONE, 2'b00, 2'b00, 1'b0); tick();
        clr(); rwE = 1'b1; rdE = 5'd4; wbselE = 2'b01; rs2D = 5'd4; rs2u = 1'b1;
        chk("nofwd_raw_E", C_LD, 2'b00, 2'b00, 1'b0); tick();

        clr(); start = 1'b1;
        chk("vmdu_issue", C_MDU, 2'b00, 2'b00, 1'b0); tick();
        for (int i = 1; i <= 9; i++) begin
            done = (i == 9);
            chk("vmdu_busy", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        end
        done = 1'b0;
        chk("vmdu_done", C_NONE, 2'b00, 2'b00, 1'b1); tick();
        start = 1'b0;
        chk("vmdu_idle", C_NONE, 2'b00, 2'b00, 1'b0); tick();

        start = 1'b1;
        chk("rst_issue", C_MDU, 2'b00, 2'b00, 1'b0); tick();
        chk("rst_busy1", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        chk("rst_busy2", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        rst = 1'b1;
        chk("rst_busy3", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        rst = 1'b0; start = 1'b0;
        chk("after_mid_rst", C_NONE, 2'b00, 2'b00, 1'b0); tick();

        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("sat_stall", C_MDU, 2'b00, 2'b00, (i != 0)); tick();
        end
        chk("sat_hold15", C_MDU, 2'b00, 2'b00, 1'b1); tick();
        rst = 1'b1; start = 1'b0; tick();
        rst = 1'b0;

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
